// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage. It issues word-aligned read requests to the
// instruction memory, places the returned words in a small in-order buffer,
// and presents the buffer head to the decode stage. A taken branch/jump
// (i_jump_en) flushes the buffer and redirects fetch. If the redirect
// arrives while a memory request is still outstanding, the response to that
// old request is discarded when it eventually arrives.
//
// Parameters
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  fetched-instruction buffer entries (power of two, >= 2)
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_reset      synchronous active-high reset
//   o_imem_req   read request, held until i_imem_ack
//   o_imem_addr  word-aligned read address, stable while o_imem_req=1
//   i_imem_ack   memory completes the current request this cycle
//   i_imem_data  instruction word, valid with i_imem_ack
//   i_jump_en    redirect fetch to i_jump_addr
//   i_jump_addr  redirect target (low two bits ignored)
//   i_stall      downstream cannot accept the presented instruction
//   o_valid      o_pc_addr/o_inst_data hold a valid instruction
//   o_pc_addr    pc of the presented instruction (0 when not valid)
//   o_inst_data  presented instruction (NOP when not valid)
// ---------------------------------------------------------------------------
module inst_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_data,
   input  logic        i_jump_en,
   input  logic [31:0] i_jump_addr,
   input  logic        i_stall,
   output logic        o_valid,
   output logic [31:0] o_pc_addr,
   output logic [31:0] o_inst_data
);

   localparam int unsigned     PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned     CNT_W    = $clog2(BUF_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
   localparam logic [31:0]     NOP_INST = 32'h0000_0013;

   // S_IDLE: no request outstanding
   // S_BUSY: request outstanding for fpc
   // S_DROP: request outstanding for a stale address; its data is thrown away
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DROP = 2'd2
   } fetch_state_e;

   fetch_state_e     state_q, state_d;
   logic [31:0]      fpc_q, fpc_d;
   logic [31:0]      drop_addr_q, drop_addr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      buf_pc_q   [BUF_DEPTH];
   logic [31:0]      buf_pc_d   [BUF_DEPTH];
   logic [31:0]      buf_inst_q [BUF_DEPTH];
   logic [31:0]      buf_inst_d [BUF_DEPTH];

   logic             head_valid;
   logic             pop;
   logic             push;
   logic [CNT_W-1:0] count_after;
   logic             space;
   logic             jump_addr_unused;

   // Instructions are word aligned, so the low target bits carry no meaning.
   assign jump_addr_unused = ^i_jump_addr[1:0];

   // A jump overrides both buffer operations for the cycle. "space" looks at
   // the occupancy as it will be after this cycle's pop and push, so a full
   // buffer being drained this cycle already allows the next request.
   always_comb begin
      head_valid  = (count_q != '0);
      pop         = head_valid && !i_stall && !i_jump_en;
      push        = (state_q == S_BUSY) && i_imem_ack && !i_jump_en;
      count_after = count_q - {{(CNT_W-1){1'b0}}, pop}
                            + {{(CNT_W-1){1'b0}}, push};
      space       = (count_after < DEPTH_C);
   end

   always_comb begin
      state_d     = state_q;
      fpc_d       = fpc_q;
      drop_addr_d = drop_addr_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_after;
      buf_pc_d    = buf_pc_q;
      buf_inst_d  = buf_inst_q;

      if (push) begin
         buf_pc_d[wr_ptr_q]   = fpc_q;
         buf_inst_d[wr_ptr_q] = i_imem_data;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
         fpc_d                = fpc_q + 32'd4;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      // In S_BUSY a push always fits: the request was only launched when the
      // buffer had room, and only pops have happened since.
      case (state_q)
         S_IDLE: begin
            if (space) begin
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (i_imem_ack) begin
               state_d = space ? S_BUSY : S_IDLE;
            end
         end
         S_DROP: begin
            if (i_imem_ack) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Redirect: flush everything and restart from the target. An
      // unacknowledged request cannot be withdrawn, so its address is kept
      // on the bus in S_DROP until the memory answers.
      if (i_jump_en) begin
         fpc_d    = {i_jump_addr[31:2], 2'b00};
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         case (state_q)
            S_BUSY: begin
               if (i_imem_ack) begin
                  state_d = S_IDLE;
               end else begin
                  state_d     = S_DROP;
                  drop_addr_d = fpc_q;
               end
            end
            S_DROP: begin
               state_d = i_imem_ack ? S_IDLE : S_DROP;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         fpc_q       <= RESET_PC;
         drop_addr_q <= RESET_PC;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         fpc_q       <= fpc_d;
         drop_addr_q <= drop_addr_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
      end
   end

   // Buffer storage needs no reset: entries are only visible through
   // count_q, which reset clears.
   always_ff @(posedge i_clk) begin
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
   end

   always_comb begin
      o_imem_req  = (state_q != S_IDLE);
      o_imem_addr = (state_q == S_DROP) ? drop_addr_q : fpc_q;
      o_valid     = head_valid;
      o_pc_addr   = 32'h0;
      o_inst_data = NOP_INST;
      if (head_valid) begin
         o_pc_addr   = buf_pc_q[rd_ptr_q];
         o_inst_data = buf_inst_q[rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//
// Self-checking bench for inst_fetch. A behavioural memory answers requests
// after a programmable number of wait cycles with data = addr ^ mem_xor. A
// scoreboard queue holds the program-order pcs expected on the output; it is
// refilled from RESET_PC on reset and from the target on every jump, and
// every instruction consumed by the downstream stage is popped and compared.
// Directed sequences check the fetch handshake around stalls, jumps, resets
// and spurious acknowledges.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int unsigned BUF_DEPTH = 2;
   localparam logic [31:0] NOP_INST  = 32'h0000_0013;
   localparam logic [31:0] DATA_KEY  = 32'h5A5A_0000;

   logic        i_clk;
   logic        i_reset;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic [31:0] i_imem_data;
   logic        i_jump_en;
   logic [31:0] i_jump_addr;
   logic        i_stall;
   logic        o_valid;
   logic [31:0] o_pc_addr;
   logic [31:0] o_inst_data;

   int          checks   = 0;
   int          failures = 0;
   int          consumed = 0;
   int          mem_lat  = 0;
   int          mem_wait = 0;
   logic [31:0] mem_xor  = 32'h0;
   logic        spur_ack = 1'b0;
   logic [31:0] exp_q [$];

   inst_fetch #(
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (BUF_DEPTH)
   ) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .o_imem_req  (o_imem_req),
      .o_imem_addr (o_imem_addr),
      .i_imem_ack  (i_imem_ack),
      .i_imem_data (i_imem_data),
      .i_jump_en   (i_jump_en),
      .i_jump_addr (i_jump_addr),
      .i_stall     (i_stall),
      .o_valid     (o_valid),
      .o_pc_addr   (o_pc_addr),
      .o_inst_data (o_inst_data)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic sbRestart(input logic [31:0] start);
      logic [31:0] a;
      exp_q.delete();
      a = {start[31:2], 2'b00};
      for (int i = 0; i < 256; i++) begin
         exp_q.push_back(a);
         a = a + 32'd4;
      end
   endtask

   // Inputs change on the falling edge; the DUT samples them on the next
   // rising edge.
   task automatic applyStimulus(input logic rst, input logic stall, input logic jmp,
                                input logic [31:0] jaddr, input logic spur);
      @(negedge i_clk);
      i_reset     = rst;
      i_stall     = stall;
      i_jump_en   = jmp;
      i_jump_addr = jaddr;
      spur_ack    = spur;
      if (rst) begin
         sbRestart(RESET_PC);
      end else if (jmp) begin
         sbRestart(jaddr);
      end
   endtask

   task automatic applyReset(input int lat, input logic [31:0] key, input logic stall);
      applyStimulus(1'b1, stall, 1'b0, 32'h0, 1'b0);
      mem_lat = lat;
      mem_xor = key;
      applyStimulus(1'b1, stall, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      end
   endtask

   task automatic checkIdleOutputs(input string tag, input logic [31:0] addr);
      checkOutput({tag, "_req"},   32'(o_imem_req), 32'd0);
      checkOutput({tag, "_addr"},  o_imem_addr, addr);
      checkOutput({tag, "_valid"}, 32'(o_valid), 32'd0);
      checkOutput({tag, "_pc"},    o_pc_addr, 32'h0);
      checkOutput({tag, "_inst"},  o_inst_data, NOP_INST);
   endtask

   // Memory model: answers after mem_lat wait cycles; while no request is
   // outstanding it drives spur_ack with junk data.
   initial begin
      i_imem_ack  = 1'b0;
      i_imem_data = 32'h0;
      forever begin
         @(negedge i_clk);
         #1;
         if (o_imem_req) begin
            if (mem_wait >= mem_lat) begin
               i_imem_ack  = 1'b1;
               i_imem_data = o_imem_addr ^ mem_xor;
               mem_wait    = 0;
            end else begin
               i_imem_ack  = 1'b0;
               i_imem_data = 32'h0;
               mem_wait++;
            end
         end else begin
            mem_wait    = 0;
            i_imem_ack  = spur_ack;
            i_imem_data = 32'hDEAD_BEEF;
         end
      end
   end

   // Scoreboard consumer: every instruction accepted downstream must be the
   // next pc in program order carrying that pc's memory word.
   initial begin
      logic [31:0] exp_pc;
      forever begin
         @(negedge i_clk);
         #2;
         if (!i_reset && o_valid && !i_stall && !i_jump_en) begin
            checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               exp_pc = exp_q.pop_front();
               checkOutput("out_pc", o_pc_addr, exp_pc);
               checkOutput("out_inst", o_inst_data, exp_pc ^ mem_xor);
               consumed++;
            end
         end
      end
   end

   initial begin
      int   mark;
      logic stall_r;
      logic jmp_r;
      logic prev_jmp;
      logic [31:0] jaddr_r;

      i_reset     = 1'b1;
      i_stall     = 1'b0;
      i_jump_en   = 1'b0;
      i_jump_addr = 32'h0;

      // Zero-wait streaming, data equals address
      $display("[TB] zero-wait streaming");
      applyReset(0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1 checkIdleOutputs("reset", RESET_PC);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("first_req", 32'(o_imem_req), 32'd1);
      checkOutput("first_addr", o_imem_addr, RESET_PC);
      checkOutput("first_not_valid", 32'(o_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("first_valid", 32'(o_valid), 32'd1);
      checkOutput("first_pc", o_pc_addr, RESET_PC);
      checkOutput("first_inst", o_inst_data, RESET_PC);
      checkOutput("second_addr", o_imem_addr, RESET_PC + 32'd4);
      mark = consumed;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
         #1 checkOutput("stream_valid", 32'(o_valid), 32'd1);
      end
      checkOutput("stream_progress", 32'(consumed - mark >= 20), 32'd1);

      // Five stall cycles, spurious acks while idle with a full buffer
      $display("[TB] stall and spurious ack");
      applyReset(0, DATA_KEY, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      #1 checkIdleOutputs("stall_reset", RESET_PC);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      #1 checkOutput("stall_req1", 32'(o_imem_req), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("stall_req2", 32'(o_imem_req), 32'd1);
      checkOutput("stall_pc_a", o_pc_addr, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      #1;
      checkOutput("stall_req_drop", 32'(o_imem_req), 32'd0);
      checkOutput("stall_pc_b", o_pc_addr, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      #1;
      checkOutput("spur_req", 32'(o_imem_req), 32'd0);
      checkOutput("spur_inst", o_inst_data, 32'h0 ^ DATA_KEY);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("spur_req_after", 32'(o_imem_req), 32'd0);
      checkOutput("spur_valid_after", 32'(o_valid), 32'd1);
      checkOutput("spur_pc_after", o_pc_addr, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("release_pc", o_pc_addr, 32'h4);
      checkOutput("release_req", 32'(o_imem_req), 32'd1);
      checkOutput("release_addr", o_imem_addr, 32'h8);
      mark = consumed;
      runCycles(10);
      checkOutput("release_progress", 32'(consumed - mark >= 8), 32'd1);

      // Jump with a full buffer while idle and stalled
      $display("[TB] jump with full buffer");
      applyReset(0, DATA_KEY, 1'b1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0203, 1'b1);
      #1;
      checkOutput("full_valid", 32'(o_valid), 32'd1);
      checkOutput("full_req", 32'(o_imem_req), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1 checkIdleOutputs("full_jump", 32'h0000_0200);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("full_jump_req", 32'(o_imem_req), 32'd1);
      checkOutput("full_jump_addr", o_imem_addr, 32'h0000_0200);
      mark = consumed;
      runCycles(10);
      checkOutput("full_jump_progress", 32'(consumed - mark >= 8), 32'd1);

      // Jump in the same cycle as an acknowledge
      $display("[TB] jump coincident with ack");
      applyReset(0, DATA_KEY, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0203, 1'b0);
      #1;
      checkOutput("ackjmp_pre_valid", 32'(o_valid), 32'd1);
      checkOutput("ackjmp_pre_addr", o_imem_addr, 32'h4);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1 checkIdleOutputs("ackjmp", 32'h0000_0200);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("ackjmp_req", 32'(o_imem_req), 32'd1);
      checkOutput("ackjmp_addr", o_imem_addr, 32'h0000_0200);
      runCycles(10);

      // Three wait states, jump in the second wait cycle
      $display("[TB] jump during wait states");
      applyReset(3, DATA_KEY, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1 checkIdleOutputs("lat_reset", RESET_PC);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1 checkOutput("lat_req", 32'(o_imem_req), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
      #1 checkOutput("lat_addr_wait", o_imem_addr, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("drop_req", 32'(o_imem_req), 32'd1);
      checkOutput("drop_addr", o_imem_addr, 32'h0);
      checkOutput("drop_valid", 32'(o_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1 checkOutput("drop_addr_hold", o_imem_addr, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1 checkIdleOutputs("drop_done", 32'h0000_0100);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("redirect_req", 32'(o_imem_req), 32'd1);
      checkOutput("redirect_addr", o_imem_addr, 32'h0000_0100);
      mark = consumed;
      runCycles(12);
      checkOutput("redirect_progress", 32'(consumed - mark >= 2), 32'd1);

      // Reset while a request is outstanding, memory answers a cycle later
      $display("[TB] reset during request");
      applyReset(1, DATA_KEY, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1 checkIdleOutputs("rbusy_reset", RESET_PC);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      #1 checkOutput("rbusy_req", 32'(o_imem_req), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      #1 checkIdleOutputs("rbusy_abort", RESET_PC);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("rbusy_valid", 32'(o_valid), 32'd0);
      checkOutput("rbusy_refetch_req", 32'(o_imem_req), 32'd1);
      checkOutput("rbusy_refetch_addr", o_imem_addr, RESET_PC);
      mark = consumed;
      runCycles(10);
      checkOutput("rbusy_progress", 32'(consumed - mark >= 3), 32'd1);

      // Fetch pc wraps past the top of the address space
      $display("[TB] pc wrap");
      applyReset(0, DATA_KEY, 1'b0);
      runCycles(4);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF9, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1 checkIdleOutputs("wrap_jump", 32'hFFFF_FFF8);
      mark = consumed;
      runCycles(12);
      checkOutput("wrap_progress", 32'(consumed - mark >= 6), 32'd1);

      // Random stalls and jumps against the scoreboard
      $display("[TB] random traffic");
      applyReset(int'($urandom_range(0, 2)), DATA_KEY, 1'b0);
      prev_jmp = 1'b0;
      mark = consumed;
      for (int i = 0; i < 150; i++) begin
         stall_r = ($urandom_range(0, 3) == 0);
         jmp_r   = ($urandom_range(0, 15) == 0);
         jaddr_r = $urandom;
         applyStimulus(1'b0, stall_r, jmp_r, jaddr_r, 1'b0);
         #1;
         if (prev_jmp) begin
            checkOutput("post_jump_valid", 32'(o_valid), 32'd0);
         end
         prev_jmp = jmp_r;
      end
      checkOutput("random_progress", 32'(consumed - mark >= 10), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, 2, entries in the fetched-instruction buffer (power of two, >=2).
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 o_imem_req  out  1  instruction-memory read request, held until acknowledged.
REQ-006 o_imem_addr  out  32  word-aligned read address, stable while o_imem_req=1.
REQ-007 i_imem_ack  in  1  memory completes the current request this cycle; may assert in the same cycle as o_imem_req.
REQ-008 i_imem_data  in  32  instruction word, valid when i_imem_ack=1.
REQ-009 i_jump_en  in  1  redirect fetch (branch/jump taken in ex).
REQ-010 i_jump_addr  in  32  redirect target.
REQ-011 i_stall  in  1  downstream (if_id) cannot accept this cycle.
REQ-012 o_valid  out  1  o_pc_addr/o_inst_data hold a valid instruction.
REQ-013 o_pc_addr  out  32  pc of the presented instruction.
REQ-014 o_inst_data  out  32  presented instruction.

Function
REQ-015 Fetch pc register fpc; three states: IDLE (no request), BUSY (o_imem_req=1, addr=fpc), DROP (o_imem_req=1, response to be discarded).
REQ-016 Buffer occupancy after this cycle = count - pop + push; "space" means that value < BUF_DEPTH.
REQ-017 IDLE -> BUSY when space exists; otherwise remain IDLE.
REQ-018 BUSY with i_imem_ack=1: push {fpc, i_imem_data}, fpc <= fpc+4; stay BUSY if space remains after push, else IDLE.
REQ-019 BUSY without ack: hold o_imem_req=1 and o_imem_addr unchanged.
REQ-020 With a zero-wait memory (ack same cycle as req) and i_stall=0, one instruction is fetched per cycle.
REQ-021 Push-to-output latency: one cycle (pushed entry visible on o_* the following cycle when buffer was empty).
REQ-022 o_valid = buffer non-empty; o_pc_addr/o_inst_data = head entry; head popped when o_valid=1 and i_stall=0.
REQ-023 When o_valid=0: o_pc_addr = 32'h0, o_inst_data = 32'h0000_0013 (NOP).
REQ-024 Simultaneous push and pop on a full buffer is legal and keeps occupancy constant.
REQ-025 fpc wraps from 32'hFFFF_FFFC to 32'h0 with no error indication.
REQ-026 i_jump_en=1 has priority over push and pop: buffer cleared, fpc <= {i_jump_addr[31:2], 2'b00}, response of that cycle discarded.
REQ-027 Jump in BUSY without ack -> DROP; jump in BUSY with ack, or in IDLE -> IDLE (new request next cycle).
REQ-028 DROP: hold old address/request until ack, discard data, -> IDLE; a further jump in DROP only updates fpc.
REQ-029 o_valid=0 in the cycle after any jump.
REQ-030 i_imem_ack while o_imem_req=0 is ignored.
REQ-031 i_stall does not block fetching while space exists.

Reset
REQ-032 i_reset=1 on a clock edge: state IDLE, fpc = RESET_PC, buffer empty; next cycle o_imem_req=0, o_imem_addr=RESET_PC, o_valid=0, o_pc_addr=0, o_inst_data=32'h0000_0013.
REQ-033 Reset mid-request (BUSY or DROP) abandons the transaction; no data from it is ever pushed.
REQ-034 First request (addr RESET_PC) asserted in the cycle after the first cycle with i_reset=0.

Verification
REQ-035 Zero-wait memory returning addr as data, i_stall=0 -> o_valid continuous from 2nd cycle after request, o_pc_addr 0,4,8,... with o_inst_data = o_pc_addr.
REQ-036 i_stall=1 for 5 cycles, BUF_DEPTH=2 -> o_imem_req drops after 2 pushes, o_pc_addr held at 0x0; on release sequence continues 0x4,0x8 with no gap or duplicate.
REQ-037 3-cycle ack latency, jump to 0x100 in 2nd wait cycle -> ack data for old addr discarded, next o_imem_addr=0x100, first valid o_pc_addr=0x100.
REQ-038 Jump with i_jump_addr=0x203 coincident with ack and full buffer -> buffer flushed, o_valid=0 next cycle, next fetch addr 0x200.
REQ-039 i_reset asserted during BUSY, memory acks one cycle later -> ack ignored, o_valid stays 0, refetch starts at RESET_PC.
REQ-040 Spurious i_imem_ack with o_imem_req=0 in IDLE (full buffer, stalled) -> occupancy and outputs unchanged.
